// File: rtl/render_sequencer.sv
// render_sequencer: frame-level sequencer raster -> wireframe flip -> colorloop -> fb flip/transfer.
// Latency: every control output is registered, one cycle after the event that triggers it.
// Backpressure: triangles accepted only in IDLE with no watchdog error; FB_WAIT stalls while the previous transfer runs.
//
// Ports:
//   clk, n_rst                  clock, asynchronous active-low reset
//   tri_ready, frame_last       host triangle offer and end-of-frame marker
//   tri_read                    one-cycle accept pulse back to the host
//   ras_start, ras_done         rasterizer start pulse / completion
//   wf_flip, color_en           wireframe buffer flip and colorloop start
//   cl_done[NUM_CF_MODS]        per-channel colorloop done pulses
//   fb_flip, new_frame          frame-buffer flip and new-frame pulse
//   xfer_start, transfer_done   frame-buffer transfer handshake
//   busy, frame_count           activity flag and completed-frame counter
//   timeout_err                 sticky watchdog error
module render_sequencer #(
   parameter int NUM_CF_MODS    = 4,
   parameter int FRAME_CNT_BITS = 16,
   parameter int TIMEOUT_CYCLES = 1048576,
   parameter int TO_BITS        = 21
) (
   input  logic                      clk,
   input  logic                      n_rst,
   input  logic                      tri_ready,
   input  logic                      frame_last,
   output logic                      tri_read,
   output logic                      ras_start,
   input  logic                      ras_done,
   output logic                      wf_flip,
   output logic                      color_en,
   input  logic [NUM_CF_MODS-1:0]    cl_done,
   output logic                      fb_flip,
   output logic                      new_frame,
   output logic                      xfer_start,
   input  logic                      transfer_done,
   output logic                      busy,
   output logic [FRAME_CNT_BITS-1:0] frame_count,
   output logic                      timeout_err
);

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_RASTER,
      ST_COLOR,
      ST_FB_WAIT
   } state_t;

   localparam logic [TO_BITS-1:0] WD_LAST = TO_BITS'(TIMEOUT_CYCLES - 1);

   state_t                    state, state_nxt;
   logic                      last_flag, last_flag_nxt;
   logic                      xfer_busy, xfer_busy_nxt;
   logic                      xfer_set;
   logic [TO_BITS-1:0]        wd, wd_nxt;
   logic [NUM_CF_MODS-1:0]    done_lat, done_lat_nxt;
   logic [NUM_CF_MODS-1:0]    cl_merged;
   logic                      wd_expired;
   logic                      err_nxt;
   logic [FRAME_CNT_BITS-1:0] fc_nxt;
   logic                      tri_read_nxt, ras_start_nxt, wf_flip_nxt, color_en_nxt;
   logic                      fb_flip_nxt, new_frame_nxt, xfer_start_nxt, busy_nxt;

   always_comb begin
      state_nxt      = state;
      last_flag_nxt  = last_flag;
      wd_nxt         = wd;
      done_lat_nxt   = done_lat;
      err_nxt        = timeout_err;
      fc_nxt         = frame_count;
      tri_read_nxt   = 1'b0;
      ras_start_nxt  = 1'b0;
      wf_flip_nxt    = 1'b0;
      color_en_nxt   = 1'b0;
      fb_flip_nxt    = 1'b0;
      new_frame_nxt  = 1'b0;
      xfer_start_nxt = 1'b0;
      xfer_set       = 1'b0;
      wd_expired     = (wd == WD_LAST);
      // color_en is high only on the first COLOR cycle, when the latches were
      // just cleared: done bits arriving then are dropped rather than latched.
      cl_merged      = color_en ? '0 : (done_lat | cl_done);

      case (state)
         ST_IDLE: begin
            if (tri_ready && !timeout_err) begin
               tri_read_nxt  = 1'b1;
               ras_start_nxt = 1'b1;
               last_flag_nxt = frame_last;
               wd_nxt        = '0;
               state_nxt     = ST_RASTER;
            end
         end
         ST_RASTER: begin
            if (ras_done) begin
               wf_flip_nxt  = 1'b1;
               color_en_nxt = 1'b1;
               done_lat_nxt = '0;
               wd_nxt       = '0;
               state_nxt    = ST_COLOR;
            end else if (wd_expired) begin
               err_nxt   = 1'b1;
               wd_nxt    = '0;
               state_nxt = ST_IDLE;
            end else begin
               wd_nxt = wd + 1'b1;
            end
         end
         ST_COLOR: begin
            done_lat_nxt = cl_merged;
            if (&cl_merged) begin
               wd_nxt    = '0;
               state_nxt = last_flag ? ST_FB_WAIT : ST_IDLE;
            end else if (wd_expired) begin
               err_nxt   = 1'b1;
               wd_nxt    = '0;
               state_nxt = ST_IDLE;
            end else begin
               wd_nxt = wd + 1'b1;
            end
         end
         ST_FB_WAIT: begin
            // A transfer_done arriving now frees the frame buffer this cycle.
            if (!xfer_busy || transfer_done) begin
               fb_flip_nxt    = 1'b1;
               new_frame_nxt  = 1'b1;
               xfer_start_nxt = 1'b1;
               xfer_set       = 1'b1;
               fc_nxt         = frame_count + 1'b1;
               state_nxt      = ST_IDLE;
            end
         end
         default: state_nxt = ST_IDLE;
      endcase

      // A new transfer start overrides the completion of the previous one.
      xfer_busy_nxt = xfer_set | (xfer_busy & ~transfer_done);
      busy_nxt      = (state_nxt != ST_IDLE) | xfer_busy_nxt;
   end

   always_ff @(posedge clk or negedge n_rst) begin
      if (!n_rst) begin
         state       <= ST_IDLE;
         last_flag   <= 1'b0;
         xfer_busy   <= 1'b0;
         wd          <= '0;
         done_lat    <= '0;
         timeout_err <= 1'b0;
         frame_count <= '0;
         tri_read    <= 1'b0;
         ras_start   <= 1'b0;
         wf_flip     <= 1'b0;
         color_en    <= 1'b0;
         fb_flip     <= 1'b0;
         new_frame   <= 1'b0;
         xfer_start  <= 1'b0;
         busy        <= 1'b0;
      end else begin
         state       <= state_nxt;
         last_flag   <= last_flag_nxt;
         xfer_busy   <= xfer_busy_nxt;
         wd          <= wd_nxt;
         done_lat    <= done_lat_nxt;
         timeout_err <= err_nxt;
         frame_count <= fc_nxt;
         tri_read    <= tri_read_nxt;
         ras_start   <= ras_start_nxt;
         wf_flip     <= wf_flip_nxt;
         color_en    <= color_en_nxt;
         fb_flip     <= fb_flip_nxt;
         new_frame   <= new_frame_nxt;
         xfer_start  <= xfer_start_nxt;
         busy        <= busy_nxt;
      end
   end

endmodule

// File: tb/tb_render_sequencer.sv
// tb_render_sequencer: randomized and directed stimulus for render_sequencer.
// Latency: a reference model predicts every output for each cycle.
// Backpressure: responders answer start pulses after random delays.
module tb_render_sequencer;
   localparam int TO = 64;

   logic        clk = 1'b0;
   logic        n_rst = 1'b0;
   logic        tri_ready = 1'b0;
   logic        frame_last = 1'b0;
   logic        ras_done = 1'b0;
   logic [3:0]  cl_done = 4'h0;
   logic        transfer_done = 1'b0;
   logic        tri_read, ras_start, wf_flip, color_en;
   logic        fb_flip, new_frame, xfer_start, busy, timeout_err;
   logic [15:0] frame_count;

   render_sequencer #(
      .NUM_CF_MODS(4), .FRAME_CNT_BITS(16), .TIMEOUT_CYCLES(TO), .TO_BITS(21)
   ) dut (
      .clk(clk), .n_rst(n_rst), .tri_ready(tri_ready), .frame_last(frame_last),
      .tri_read(tri_read), .ras_start(ras_start), .ras_done(ras_done),
      .wf_flip(wf_flip), .color_en(color_en), .cl_done(cl_done),
      .fb_flip(fb_flip), .new_frame(new_frame), .xfer_start(xfer_start),
      .transfer_done(transfer_done), .busy(busy), .frame_count(frame_count),
      .timeout_err(timeout_err)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   // ---------------- reference model ----------------
   // stage: 0 waiting for a triangle, 1 rasterizing, 2 colouring, 3 waiting for frame buffer
   int          m_stage, m_age;
   bit          m_last, m_xbusy, m_err;
   logic [3:0]  m_seen;
   logic [15:0] m_fc;
   bit          e_tri, e_ras, e_wf, e_col, e_fb, e_nf, e_xs;

   task automatic m_reset();
      m_stage = 0; m_age = 0; m_last = 0; m_xbusy = 0; m_err = 0; m_seen = 0; m_fc = 0;
      e_tri = 0; e_ras = 0; e_wf = 0; e_col = 0; e_fb = 0; e_nf = 0; e_xs = 0;
   endtask

   task automatic m_step();
      bit first_col;
      bit xset;
      first_col = e_col;
      xset = 0;
      e_tri = 0; e_ras = 0; e_wf = 0; e_col = 0; e_fb = 0; e_nf = 0; e_xs = 0;
      if (m_stage == 0) begin
         if (tri_ready && !m_err) begin
            e_tri = 1; e_ras = 1; m_last = frame_last; m_stage = 1; m_age = 0;
         end
      end else if (m_stage == 1) begin
         if (ras_done) begin
            e_wf = 1; e_col = 1; m_seen = 0; m_stage = 2; m_age = 0;
         end else if (m_age == TO - 1) begin
            m_err = 1; m_stage = 0;
         end else m_age++;
      end else if (m_stage == 2) begin
         if (!first_col) m_seen = m_seen | cl_done;
         if (m_seen == 4'hF) m_stage = m_last ? 3 : 0;
         else if (m_age == TO - 1) begin
            m_err = 1; m_stage = 0;
         end else m_age++;
      end else begin
         if (!m_xbusy || transfer_done) begin
            e_fb = 1; e_nf = 1; e_xs = 1; m_fc = m_fc + 16'd1; xset = 1; m_stage = 0;
         end
      end
      if (xset) m_xbusy = 1;
      else if (transfer_done) m_xbusy = 0;
   endtask

   initial begin
      m_reset();
      forever begin
         @(posedge clk or negedge n_rst);
         if (!n_rst) m_reset();
         else m_step();
      end
   end

   logic [24:0] dut_v, exp_v;
   assign dut_v = {tri_read, ras_start, wf_flip, color_en, fb_flip, new_frame, xfer_start,
                   busy, timeout_err, frame_count};
   assign exp_v = {e_tri, e_ras, e_wf, e_col, e_fb, e_nf, e_xs,
                   (m_stage != 0) || m_xbusy, m_err, m_fc};

   // ---------------- checking and stimulus ----------------
   int vectors = 0, miscompares = 0;
   int n_tri = 0, n_ras = 0, n_wf = 0, n_fb = 0;
   int t_ras = 0, t_color = 0, t_fb = 0;
   bit auto_rc = 0, auto_xf = 0, auto_tri = 0;
   int ras_cnt = -1, xf_cnt = -1;
   int cl_cnt[4] = '{-1, -1, -1, -1};

   task automatic chk(input string name, input int act, input int want);
      vectors++;
      if (act !== want) begin
         miscompares++;
         $display("FAIL %s: got %0d, expected %0d (cycle %0d)", name, act, want, cyc);
      end
   endtask

   // One clock cycle: compare at the falling edge, then drive the next inputs.
   task automatic slot();
      @(negedge clk);
      vectors++;
      if (dut_v !== exp_v) begin
         miscompares++;
         if (miscompares <= 40)
            $display("FAIL cycle_compare cycle %0d: dut %h, model %h", cyc, dut_v, exp_v);
      end
      n_tri += int'(tri_read);
      n_ras += int'(ras_start);
      n_wf  += int'(wf_flip);
      n_fb  += int'(fb_flip);
      if (ras_start) t_ras = cyc;
      if (color_en)  t_color = cyc;
      if (fb_flip)   t_fb = cyc;
      #1;
      if (auto_rc) begin
         if (ras_start) ras_cnt = $urandom_range(0, 8);
         if (color_en) for (int i = 0; i < 4; i++) cl_cnt[i] = $urandom_range(1, 10);
         ras_done = (ras_cnt == 0) || ($urandom_range(0, 15) == 0);
         if (ras_cnt >= 0) ras_cnt--;
         for (int i = 0; i < 4; i++) begin
            cl_done[i] = (cl_cnt[i] == 0) || ($urandom_range(0, 19) == 0);
            if (cl_cnt[i] >= 0) cl_cnt[i]--;
         end
      end
      if (auto_xf) begin
         if (xfer_start) xf_cnt = $urandom_range(0, 40);
         transfer_done = (xf_cnt == 0) || ($urandom_range(0, 31) == 0);
         if (xf_cnt >= 0) xf_cnt--;
      end
      if (auto_tri) begin
         tri_ready  = ($urandom_range(0, 3) != 0);
         frame_last = ($urandom_range(0, 2) == 0);
      end
   endtask

   function automatic logic sig(input int sel);
      case (sel)
         0: return ras_start;
         1: return color_en;
         2: return fb_flip;
         default: return timeout_err;
      endcase
   endfunction

   task automatic wait_hi(input int sel, input int budget, input string name);
      int n;
      n = 0;
      slot();
      while (!sig(sel) && n < budget) begin
         slot();
         n++;
      end
      if (!sig(sel)) begin
         vectors++;
         miscompares++;
         $display("FAIL %s: signal not seen within %0d cycles (cycle %0d)", name, budget, cyc);
      end
   endtask

   task automatic do_reset();
      n_rst = 0;
      slot();
      slot();
      n_rst = 1;
      slot();
   endtask

   task automatic quiet_inputs();
      auto_rc = 0; auto_xf = 0; auto_tri = 0;
      tri_ready = 0; frame_last = 0; ras_done = 0; cl_done = 0; transfer_done = 0;
      ras_cnt = -1; xf_cnt = -1;
      for (int i = 0; i < 4; i++) cl_cnt[i] = -1;
   endtask

   int b_tri, b_ras, b_wf, b_fb, t_x1, td, t_r;

   initial begin
      repeat (3) slot();
      chk("reset_outputs", int'(dut_v), 0);
      n_rst = 1;
      slot();

      // Single non-last triangle.
      b_tri = n_tri; b_ras = n_ras; b_wf = n_wf; b_fb = n_fb;
      tri_ready = 1; frame_last = 0;
      wait_hi(0, 10, "s1_ras_start");
      tri_ready = 0;
      repeat (5) slot();
      ras_done = 1;
      slot();
      ras_done = 0;
      chk("s1_color_en", int'(color_en), 1);
      chk("s1_color_after_ras", t_color - t_ras, 6);
      slot();
      cl_done = 4'hF;
      slot();
      cl_done = 4'h0;
      repeat (3) slot();
      chk("s1_tri_read_count", n_tri - b_tri, 1);
      chk("s1_wf_flip_count", n_wf - b_wf, 1);
      chk("s1_fb_flip_count", n_fb - b_fb, 0);
      chk("s1_frame_count", int'(frame_count), 0);
      chk("s1_idle", int'(busy), 0);

      // Staggered colorloop completion on the last triangle of a frame.
      tri_ready = 1; frame_last = 1;
      wait_hi(0, 10, "s2_ras_start");
      tri_ready = 0; frame_last = 0;
      repeat (2) slot();
      ras_done = 1;
      slot();
      ras_done = 0;
      chk("s2_color_en", int'(color_en), 1);
      for (int off = 0; off <= 10; off++) begin
         cl_done = {off == 10, off == 3, off == 7, off == 2};
         slot();
      end
      cl_done = 4'h0;
      chk("s2_no_flip_yet", int'(fb_flip), 0);
      slot();
      chk("s2_fb_flip", int'(fb_flip), 1);
      chk("s2_new_frame", int'(new_frame), 1);
      chk("s2_xfer_start", int'(xfer_start), 1);
      chk("s2_flip_delay", t_fb - t_color, 12);
      chk("s2_frame_count", int'(frame_count), 1);
      repeat (3) slot();
      transfer_done = 1;
      slot();
      transfer_done = 0;
      slot();
      chk("s2_idle", int'(busy), 0);

      // Two one-triangle frames with the first transfer held for 200 cycles.
      do_reset();
      b_ras = n_ras; b_wf = n_wf; b_fb = n_fb;
      auto_rc = 1;
      tri_ready = 1; frame_last = 1;
      for (int n = 0; n < 200 && n_fb == b_fb; n++) slot();
      t_x1 = t_fb;
      for (int n = 0; n < 200 && n_ras - b_ras < 2; n++) slot();
      tri_ready = 0; frame_last = 0;
      chk("s3_two_accepts", n_ras - b_ras, 2);
      while (cyc < t_x1 + 200) slot();
      chk("s3_second_raster_done", n_wf - b_wf, 2);
      chk("s3_stalled_flips", n_fb - b_fb, 1);
      td = cyc;
      transfer_done = 1;
      slot();
      transfer_done = 0;
      chk("s3_fb_flip", int'(fb_flip), 1);
      chk("s3_flip_after_done", cyc - td, 1);
      chk("s3_frame_count", int'(frame_count), 2);
      quiet_inputs();
      repeat (4) slot();
      transfer_done = 1;
      slot();
      transfer_done = 0;
      slot();
      chk("s3_idle", int'(busy), 0);

      // cl_done colliding with color_en must be dropped.
      tri_ready = 1; frame_last = 0;
      wait_hi(0, 10, "s4_ras_start");
      tri_ready = 0;
      ras_done = 1;
      slot();
      ras_done = 0;
      chk("s4_color_en", int'(color_en), 1);
      cl_done = 4'h1;
      slot();
      cl_done = 4'hE;
      slot();
      cl_done = 4'h0;
      slot();
      chk("s4_still_color", int'(busy), 1);
      cl_done = 4'h1;
      slot();
      cl_done = 4'h0;
      chk("s4_done_after_fresh_bit", int'(busy), 0);

      // Randomized traffic, then drain.
      auto_rc = 1; auto_xf = 1; auto_tri = 1;
      repeat (3000) slot();
      auto_tri = 0; tri_ready = 0; frame_last = 0;
      repeat (200) slot();
      quiet_inputs();
      slot();
      chk("rand_drained", int'(busy), 0);
      chk("rand_no_timeout", int'(timeout_err), 0);

      // Reset in the middle of COLOR.
      tri_ready = 1; frame_last = 1;
      wait_hi(0, 10, "s6_ras_start");
      tri_ready = 0; frame_last = 0;
      ras_done = 1;
      slot();
      ras_done = 0;
      slot();
      cl_done = 4'h3;
      slot();
      cl_done = 4'h0;
      n_rst = 0;
      slot();
      chk("s6_in_reset", int'(dut_v), 0);
      slot();
      n_rst = 1;
      b_tri = n_tri; b_wf = n_wf; b_fb = n_fb;
      repeat (10) slot();
      chk("s6_no_tri_read", n_tri - b_tri, 0);
      chk("s6_no_flips", (n_wf - b_wf) + (n_fb - b_fb), 0);
      chk("s6_frame_count", int'(frame_count), 0);
      chk("s6_idle", int'(busy), 0);

      // Watchdog: ras_done never arrives.
      tri_ready = 1; frame_last = 0;
      wait_hi(0, 10, "s5_ras_start");
      t_r = t_ras;
      b_tri = n_tri; b_wf = n_wf;
      wait_hi(3, 100, "s5_timeout_err");
      chk("s5_timeout_cycle", cyc - t_r, 64);
      chk("s5_no_wf_flip", n_wf - b_wf, 0);
      chk("s5_aborted_idle", int'(busy), 0);
      repeat (20) slot();
      chk("s5_refuses_triangles", n_tri - b_tri, 0);
      chk("s5_sticky", int'(timeout_err), 1);
      tri_ready = 0;
      do_reset();
      chk("s5_cleared_by_reset", int'(timeout_err), 0);
      tri_ready = 1;
      wait_hi(0, 10, "s5_accept_after_reset");
      tri_ready = 0;
      slot();

      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
